// File: rtl/cpu_pkg.sv
// Shared CPU pipeline constants: register-file geometry, scoreboard widths
// and the Tnew/Tuse encodings used by the decode-stage operand controller.
package cpu_pkg;
    localparam int NREG = 32;
    localparam int AW   = 5;
    localparam int TW   = 2;
    localparam int TAGW = 3;

    localparam logic [AW-1:0] ZERO_REG = '0;

    // Tnew: cycles until a result becomes forwardable.
    localparam logic [TW-1:0] TNEW_ALU    = 2'd1;
    localparam logic [TW-1:0] TNEW_LOAD   = 2'd2;
    // Tuse: cycles until an operand is consumed.
    localparam logic [TW-1:0] TUSE_BRANCH = 2'd0;
    localparam logic [TW-1:0] TUSE_ALU    = 2'd1;
    localparam logic [TW-1:0] TUSE_STORE  = 2'd2;
endpackage

// File: rtl/sb_entry.sv
// One register's scoreboard entry: busy flag, Tnew countdown and write tag.
// Latency: state updates on the next edge; busy_nxt exposes the pending value.
// Backpressure: none; flush beats set, set beats countdown and tag-matched clear.
module sb_entry #(
    parameter int TW   = 2,
    parameter int TAGW = 3
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            flush,
    input  logic            set,
    input  logic [TW-1:0]   set_cnt,
    input  logic [TAGW-1:0] set_tag,
    input  logic            wb_hit,
    input  logic [TAGW-1:0] wb_tag,
    output logic            busy,
    output logic            busy_nxt,
    output logic [TW-1:0]   cnt,
    output logic [TAGW-1:0] tag
);
    logic [TW-1:0]   cnt_nxt;
    logic [TAGW-1:0] tag_nxt;

    always_comb begin
        busy_nxt = busy;
        cnt_nxt  = cnt;
        tag_nxt  = tag;
        if (flush) begin
            busy_nxt = 1'b0;
            cnt_nxt  = '0;
        end else if (set) begin
            busy_nxt = 1'b1;
            cnt_nxt  = set_cnt;
            tag_nxt  = set_tag;
        end else begin
            if (busy && (cnt != '0))
                cnt_nxt = cnt - TW'(1);
            // A stale tag means a younger write still owns the register.
            if (wb_hit && busy && (tag == wb_tag))
                busy_nxt = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            busy <= 1'b0;
            cnt  <= '0;
            tag  <= '0;
        end else begin
            busy <= busy_nxt;
            cnt  <= cnt_nxt;
            tag  <= tag_nxt;
        end
    end
endmodule

// File: rtl/grf_scoreboard.sv
// Decode-stage GRF scoreboard: stalls operands not ready by their Tuse, tags in-flight writes.
// Latency: id_stall/id_fire/id_tag combinational; state and busy_cnt update on the next edge.
// Backpressure: id_stall holds decode on RAW hazards or when all write tags are in flight.
module grf_scoreboard
    import cpu_pkg::*;
#(
    parameter int NREG = cpu_pkg::NREG,
    parameter int AW   = cpu_pkg::AW,
    parameter int TW   = cpu_pkg::TW,
    parameter int TAGW = cpu_pkg::TAGW
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            id_valid,
    input  logic [AW-1:0]   id_rs,
    input  logic [AW-1:0]   id_rt,
    input  logic [TW-1:0]   id_tuse_rs,
    input  logic [TW-1:0]   id_tuse_rt,
    input  logic            id_dst_we,
    input  logic [AW-1:0]   id_dst,
    input  logic [TW-1:0]   id_tnew,
    output logic            id_stall,
    output logic            id_fire,
    output logic [TAGW-1:0] id_tag,
    input  logic            wb_we,
    input  logic [AW-1:0]   wb_addr,
    input  logic [TAGW-1:0] wb_tag,
    input  logic            flush,
    output logic [AW:0]     busy_cnt
);
    localparam logic [TAGW:0] MAX_INFL = (TAGW+1)'(1) << TAGW;

    logic [NREG-1:0] busy_v;
    logic [NREG-1:0] busy_nxt_v;
    logic [TW-1:0]   cnt_v [NREG];
    logic [TAGW-1:0] tag_v [NREG];
    logic [TAGW-1:0] tag_ctr;
    logic [TAGW:0]   inflight;
    logic [TAGW:0]   inflight_nxt;
    logic            haz_rs;
    logic            haz_rt;
    logic            full;
    logic            fire_wr;
    logic            wb_act;

    // Register 0 is never tracked, so it reads as an idle entry.
    assign busy_v[0]     = 1'b0;
    assign busy_nxt_v[0] = 1'b0;
    assign cnt_v[0]      = '0;
    assign tag_v[0]      = '0;

    assign haz_rs   = (id_rs != ZERO_REG) && busy_v[id_rs] && (cnt_v[id_rs] > id_tuse_rs);
    assign haz_rt   = (id_rt != ZERO_REG) && busy_v[id_rt] && (cnt_v[id_rt] > id_tuse_rt);
    assign full     = (inflight == MAX_INFL);
    assign id_stall = id_valid && (haz_rs || haz_rt || (id_dst_we && full));
    assign id_fire  = id_valid && !id_stall;
    assign id_tag   = tag_ctr;
    assign fire_wr  = id_fire && id_dst_we && (id_dst != ZERO_REG);
    assign wb_act   = wb_we && (wb_addr != ZERO_REG);

    for (genvar i = 1; i < NREG; i++) begin : g_ent
        sb_entry #(.TW(TW), .TAGW(TAGW)) u_ent (
            .clk      (clk),
            .reset    (reset),
            .flush    (flush),
            .set      (fire_wr && (id_dst == AW'(i))),
            .set_cnt  (id_tnew),
            .set_tag  (tag_ctr),
            .wb_hit   (wb_act && (wb_addr == AW'(i))),
            .wb_tag   (wb_tag),
            .busy     (busy_v[i]),
            .busy_nxt (busy_nxt_v[i]),
            .cnt      (cnt_v[i]),
            .tag      (tag_v[i])
        );
    end

    always_comb begin
        inflight_nxt = inflight;
        if (flush)
            inflight_nxt = '0;
        else if (fire_wr && !wb_act)
            inflight_nxt = inflight + (TAGW+1)'(1);
        else if (!fire_wr && wb_act)
            inflight_nxt = inflight - (TAGW+1)'(1);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tag_ctr  <= '0;
            inflight <= '0;
            busy_cnt <= '0;
        end else begin
            inflight <= inflight_nxt;
            busy_cnt <= (AW+1)'($countones(busy_nxt_v));
            if (fire_wr && !flush)
                tag_ctr <= tag_ctr + TAGW'(1);
        end
    end
endmodule

// File: tb/tb_grf_scoreboard.sv
// Scoreboard bench for grf_scoreboard: directed scenarios then randomized traffic,
// checked against a ready-time reference model of pending register writes.
module tb_grf_scoreboard;
    import cpu_pkg::*;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       id_valid = 1'b0;
    logic [4:0] id_rs = '0, id_rt = '0, id_dst = '0, wb_addr = '0;
    logic [1:0] id_tuse_rs = '0, id_tuse_rt = '0, id_tnew = '0;
    logic       id_dst_we = 1'b0, wb_we = 1'b0, flush = 1'b0;
    logic [2:0] wb_tag = '0;
    logic       id_stall, id_fire;
    logic [2:0] id_tag;
    logic [5:0] busy_cnt;

    always #5 clk = ~clk;

    grf_scoreboard dut (
        .clk(clk), .reset(reset), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
        .id_tuse_rs(id_tuse_rs), .id_tuse_rt(id_tuse_rt), .id_dst_we(id_dst_we),
        .id_dst(id_dst), .id_tnew(id_tnew), .id_stall(id_stall), .id_fire(id_fire),
        .id_tag(id_tag), .wb_we(wb_we), .wb_addr(wb_addr), .wb_tag(wb_tag),
        .flush(flush), .busy_cnt(busy_cnt)
    );

    typedef struct {
        logic       stall;
        logic       fire;
        logic [2:0] tag;
        logic [5:0] bcnt;
        int         w_stall;
        int         w_tag;
        int         w_bcnt;
        int         cyc;
    } exp_t;
    typedef struct {
        logic [4:0] r;
        logic [2:0] t;
    } wr_t;

    exp_t sbq[$];
    wr_t  wq[$];
    exp_t me;
    wr_t  pw;

    // Reference model: a register is pending until its tag retires; its result
    // is forwardable from absolute cycle m_ready onward.
    bit m_busy[32];
    int m_ready[32];
    int m_tag[32];
    int m_tagctr, m_infl, now;
    int n_chk, n_fail;

    logic       s_v, s_we, s_wbwe, s_fl, s_rst;
    logic [4:0] s_rs, s_rt, s_dst, s_wba;
    logic [1:0] s_turs, s_turt, s_tn;
    logic [2:0] s_wbt;

    task automatic chk(input string nm, input int cyc, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %0d, required %0d", nm, cyc, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (sbq.size() > 0) begin
            me = sbq.pop_front();
            chk("id_stall", me.cyc, int'(id_stall), int'(me.stall));
            chk("id_fire", me.cyc, int'(id_fire), int'(me.fire));
            chk("id_tag", me.cyc, int'(id_tag), int'(me.tag));
            chk("busy_cnt", me.cyc, int'(busy_cnt), int'(me.bcnt));
            if (me.w_stall >= 0) chk("plan_stall", me.cyc, int'(id_stall), me.w_stall);
            if (me.w_tag >= 0)   chk("plan_tag", me.cyc, int'(id_tag), me.w_tag);
            if (me.w_bcnt >= 0)  chk("plan_busy_cnt", me.cyc, int'(busy_cnt), me.w_bcnt);
        end
    end

    function automatic int remaining(input int r);
        return (m_busy[r] && m_ready[r] > now) ? m_ready[r] - now : 0;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 32; i++) begin
            m_busy[i] = 0;
            m_ready[i] = 0;
            m_tag[i] = 0;
        end
        m_tagctr = 0;
        m_infl = 0;
        wq.delete();
    endtask

    task automatic clr();
        s_v = 0; s_we = 0; s_wbwe = 0; s_fl = 0; s_rst = 0;
        s_rs = 0; s_rt = 0; s_dst = 0; s_wba = 0;
        s_turs = 0; s_turt = 0; s_tn = 0; s_wbt = 0;
    endtask

    task automatic step(input int w_stall = -1, input int w_tag = -1, input int w_bcnt = -1);
        exp_t e;
        bit   hz_rs, hz_rt, fw;
        int   nb;
        wr_t  w;
        @(posedge clk);
        #1;
        reset = !s_rst;
        id_valid = s_v; id_rs = s_rs; id_rt = s_rt; id_tuse_rs = s_turs; id_tuse_rt = s_turt;
        id_dst_we = s_we; id_dst = s_dst; id_tnew = s_tn;
        wb_we = s_wbwe; wb_addr = s_wba; wb_tag = s_wbt; flush = s_fl;
        if (s_rst) model_reset();
        hz_rs = (s_rs != 0) && (remaining(int'(s_rs)) > int'(s_turs));
        hz_rt = (s_rt != 0) && (remaining(int'(s_rt)) > int'(s_turt));
        e.stall = s_v && (hz_rs || hz_rt || (s_we && m_infl == 8));
        e.fire  = s_v && !e.stall;
        e.tag   = 3'(m_tagctr);
        nb = 0;
        for (int i = 0; i < 32; i++) nb += int'(m_busy[i]);
        e.bcnt = 6'(nb);
        e.w_stall = w_stall; e.w_tag = w_tag; e.w_bcnt = w_bcnt; e.cyc = now;
        sbq.push_back(e);
        if (!s_rst) begin
            if (s_fl) begin
                for (int i = 0; i < 32; i++) m_busy[i] = 0;
                m_infl = 0;
                wq.delete();
            end else begin
                fw = e.fire && s_we && (s_dst != 0);
                if (s_wbwe && s_wba != 0) begin
                    m_infl--;
                    if (m_busy[s_wba] && m_tag[s_wba] == int'(s_wbt)) m_busy[s_wba] = 0;
                end
                if (fw) begin
                    m_busy[s_dst] = 1;
                    m_tag[s_dst] = m_tagctr;
                    m_ready[s_dst] = now + 1 + int'(s_tn);
                    w.r = s_dst;
                    w.t = 3'(m_tagctr);
                    wq.push_back(w);
                    m_tagctr = (m_tagctr + 1) % 8;
                    m_infl++;
                end
            end
        end
        now++;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        n_chk = 0; n_fail = 0; now = 0;
        model_reset();

        // Reset with a pending-looking request must not stall.
        clr(); s_rst = 1; s_v = 1; s_rs = 5; step(0, 0, 0);
        clr(); step();

        // Load-use: tnew=2 against tuse=0 stalls two cycles.
        clr(); s_v = 1; s_we = 1; s_dst = 8; s_tn = TNEW_LOAD; step(0);
        clr(); s_v = 1; s_rs = 8; s_turs = TUSE_BRANCH; step(1, -1, 1);
        clr(); s_v = 1; s_rs = 8; s_turs = TUSE_BRANCH; step(1);
        clr(); s_v = 1; s_rs = 8; s_turs = TUSE_BRANCH; step(0);
        clr(); s_wbwe = 1; s_wba = 8; s_wbt = 0; step();
        clr(); step(-1, -1, 0);

        // ALU result feeding store data needs no stall.
        clr(); s_v = 1; s_we = 1; s_dst = 9; s_tn = TNEW_ALU; step(0);
        clr(); s_v = 1; s_rt = 9; s_turt = TUSE_STORE; step(0, -1, 1);
        clr(); s_wbwe = 1; s_wba = 9; s_wbt = 1; step();

        // WAW: only the youngest tag retires the entry.
        clr(); s_rst = 1; step();
        clr(); s_v = 1; s_we = 1; s_dst = 4; s_tn = TNEW_ALU; step(0, 0);
        clr(); s_v = 1; s_we = 1; s_dst = 4; s_tn = TNEW_ALU; step(0, 1);
        clr(); s_wbwe = 1; s_wba = 4; s_wbt = 0; step(-1, -1, 1);
        clr(); s_wbwe = 1; s_wba = 4; s_wbt = 1; step(-1, -1, 1);
        clr(); step(-1, -1, 0);

        // Tag exhaustion and wrap.
        clr(); s_rst = 1; step();
        for (int i = 1; i <= 8; i++) begin
            clr(); s_v = 1; s_we = 1; s_dst = 5'(i); s_tn = TNEW_ALU; step(0, i - 1);
        end
        clr(); s_v = 1; s_we = 1; s_dst = 10; s_tn = TNEW_ALU;
        s_wbwe = 1; s_wba = 1; s_wbt = 0; step(1, 0, 8);
        clr(); s_v = 1; s_we = 1; s_dst = 10; s_tn = TNEW_ALU; step(0, 0, 7);

        // Reset mid-operation drops everything immediately.
        clr(); s_rst = 1; step(-1, 0, 0);
        clr(); step(-1, 0, 0);

        // Flush discards the same-cycle fire and keeps tag_ctr.
        clr(); s_v = 1; s_we = 1; s_dst = 3; s_tn = TNEW_LOAD; step(0, 0);
        clr(); s_v = 1; s_we = 1; s_dst = 6; s_tn = TNEW_LOAD; s_fl = 1; step(0, 1, 1);
        clr(); s_v = 1; s_rs = 6; s_turs = TUSE_BRANCH; step(0, -1, 0);
        clr(); s_v = 1; s_rs = 3; s_turs = TUSE_BRANCH; step(0, -1, 0);
        clr(); s_v = 1; s_we = 1; s_dst = 7; s_tn = TNEW_ALU; step(0, 1);

        // Randomized traffic with in-order writeback of issued writes.
        clr(); s_rst = 1; step();
        for (int n = 0; n < 1500; n++) begin
            clr();
            s_v    = ($urandom_range(0, 3) != 0);
            s_rs   = 5'($urandom_range(0, 7));
            s_rt   = 5'($urandom_range(0, 7));
            s_turs = 2'($urandom_range(0, 3));
            s_turt = 2'($urandom_range(0, 3));
            s_we   = ($urandom_range(0, 1) == 1);
            s_dst  = 5'($urandom_range(0, 7));
            s_tn   = 2'($urandom_range(0, 3));
            if (wq.size() > 0 && $urandom_range(0, 2) == 0) begin
                pw = wq.pop_front();
                s_wbwe = 1; s_wba = pw.r; s_wbt = pw.t;
            end else if ($urandom_range(0, 9) == 0) begin
                s_wbwe = 1; s_wba = 0; s_wbt = 3'($urandom_range(0, 7));
            end
            s_fl  = ($urandom_range(0, 59) == 0);
            s_rst = ($urandom_range(0, 199) == 0);
            step();
        end

        clr(); step();
        repeat (2) @(negedge clk);
        chk("scoreboard_drained", now, sbq.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/grf_scoreboard.md
Name: grf_scoreboard

Overview:
- Decode-stage operand-read controller on the read side of the general register file.
- Tracks every register with an in-flight write, i.e. issued but not yet written back.
- Stalls an instruction whose source operands will not be available (through the GRF write-through path or forwarding) by the cycle it needs them.
- Clears entries when writeback lands; each writeback is matched by tag so that WAW overlaps clear correctly.

Parameters:
- NREG, 32, number of architectural registers (register 0 is hardwired zero and never tracked).
- AW, 5, register address width, log2(NREG).
- TW, 2, width of the Tnew/Tuse cycle counts.
- TAGW, 3, width of the write tag; at most 2^TAGW writes may be in flight.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset (asserted at 0).
- id_valid  in  1  decode holds an instruction.
- id_rs  in  AW  source A register.
- id_rt  in  AW  source B register.
- id_tuse_rs  in  TW  cycles until rs is consumed.
- id_tuse_rt  in  TW  cycles until rt is consumed.
- id_dst_we  in  1  instruction writes a register.
- id_dst  in  AW  destination register.
- id_tnew  in  TW  cycles until the result is forwardable.
- id_stall  out  1  hold decode this cycle (combinational).
- id_fire  out  1  id_valid and not id_stall.
- id_tag  out  TAGW  tag assigned to the firing write; it travels down the pipe.
- wb_we  in  1  GRF write this cycle.
- wb_addr  in  AW  GRF write address.
- wb_tag  in  TAGW  tag of the retiring write.
- flush  in  1  synchronous clear of all in-flight state.
- busy_cnt  out  AW+1  number of registers with a pending write.

Behaviour:
- Per-register state: busy (1), cnt (TW), tag (TAGW). Global state: tag_ctr (TAGW), inflight (TAGW+1).
- Reset (async, reset=0): every busy=0, cnt=0, tag=0; tag_ctr=0; inflight=0. Outputs then read id_stall=0, id_fire=id_valid, id_tag=0, busy_cnt=0.
- Hazard on rs when rs!=0, busy[rs]=1 and cnt[rs]>id_tuse_rs. The rt hazard is defined the same way.
- A busy entry with cnt=0 never stalls, because its value is forwardable or is being written through the GRF this cycle.
- Full condition: inflight = 2^TAGW.
- id_stall = id_valid and (rs hazard, or rt hazard, or (id_dst_we and full)).
- Fire with id_dst_we=1 and id_dst!=0, at the next edge:
  - busy[id_dst]=1, cnt[id_dst]=id_tnew, tag[id_dst]=tag_ctr.
  - tag_ctr increments and wraps at 2^TAGW.
  - inflight increments.
- id_tag = tag_ctr (combinational), so it is valid in the firing cycle.
- A fire with id_dst=0 or id_dst_we=0 changes no state.
- Countdown: every edge, each busy entry with cnt>0 that is not being set by a fire decrements by 1; it saturates at 0.
- Writeback, when wb_we=1 and wb_addr!=0:
  - inflight always decrements.
  - If busy[wb_addr]=1 and tag[wb_addr]=wb_tag, busy clears.
  - On tag mismatch (a younger write is pending) the entry is untouched.
- Same cycle fire to X and writeback to X: the fire wins and the entry holds the new tag. inflight is net unchanged.
- wb_we with wb_addr=0 is ignored.
- flush=1: at the next edge all busy=0 and inflight=0. tag_ctr is retained. A same-cycle fire or writeback is discarded.
- busy_cnt is the registered population count of busy bits, updated one cycle after each change.
- Reset asserted mid-operation drops all pending state immediately.

Decomposition:
- Shared package cpu_pkg:
  - AW, TW and TAGW constants.
  - The ZERO_REG constant.
  - The tnew/tuse encodings used by the controller: ALU tnew=1, LOAD tnew=2, branch tuse=0, ALU tuse=1, store-data tuse=2.
- One natural sub-module, sb_entry: a single register's busy/cnt/tag with set, decrement and clear-on-tag-match. It is instantiated NREG-1 times.

Test Plan:
- Reset with id_valid=1 and id_rs=5 → id_stall=0, id_tag=0, busy_cnt=0.
- Fire lw with dst=8 and tnew=2; next cycle present rs=8 with tuse=0 → stall 2 cycles, then fire on the 3rd cycle, when cnt=0.
- Fire add with dst=9 and tnew=1; next cycle present store with rt=9 and tuse=2 → no stall.
- WAW:
  - Fire dst=4 (tag 0), then dst=4 (tag 1).
  - Writeback wb_addr=4 with wb_tag=0 → busy[4] stays 1 and busy_cnt=1.
  - Writeback with wb_tag=1 → busy[4]=0.
- Issue 8 writes with no writeback → 9th write stalls with id_stall=1. One writeback → it fires the next cycle with id_tag=0, since tag_ctr wrapped.
- Pending dst=3; flush=1 alongside a fire to dst=6 → next cycle busy_cnt=0, no entry set, and rs=6/rs=3 do not stall.
